formation_ctrl: RTL and testbench

FORMATION_CTRL -- requirements
Module: formation_ctrl

---
 rtl/formation_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_formation_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/formation_ctrl.sv
// formation_ctrl: marching enemy formation -- horizontal sweep, edge descent, level, shooter scan.
// Build option FORMATION_ALIVE_SPEEDUP_EN: step grows by 1 px while a quarter or fewer enemies live.
module formation_ctrl #(
  parameter int unsigned ROWS      = 5,
  parameter int unsigned COLS      = 13,
  parameter int unsigned DIST_COL  = 30,
  parameter int unsigned DIST_ROW  = 30,
  parameter int unsigned X0        = 150,
  parameter int unsigned Y0        = 40,
  parameter int unsigned X_MIN     = 120,
  parameter int unsigned X_MAX     = 760,
  parameter int unsigned DELTA_Y   = 50,
  parameter int unsigned Y_LIMIT   = 440,
  parameter int unsigned STEP_DIV  = 2097152,
  parameter int unsigned SHOT_DIV  = 10000000,
  parameter int unsigned MAX_LEVEL = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 restart,
  input  logic                 run,
  input  logic [ROWS*COLS-1:0] alive,
  output logic [9:0]           base_x,
  output logic [9:0]           base_y,
  output logic                 direction,
  output logic [3:0]           level,
  output logic                 step_pulse,
  output logic                 shot_pulse,
  output logic [6:0]           shooter_id,
  output logic                 invaded,
  output logic                 cleared
);

  localparam int unsigned N  = ROWS * COLS;
  localparam int unsigned AW = 11;
  localparam int unsigned PW = 10;
  localparam int unsigned IW = 7;
  localparam int unsigned CW = 8;
  localparam int unsigned SW = $clog2(STEP_DIV + 1);
  localparam int unsigned TW = $clog2(SHOT_DIV + 1);
  localparam logic [AW-1:0] PIX_MAX = AW'(1023);

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DESCEND, S_HALT} state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   step_cnt, step_cnt_nxt;
  logic [TW-1:0]   shot_cnt, shot_cnt_nxt;
  logic            scanning, scanning_nxt;
  logic [IW-1:0]   scan_idx, scan_idx_nxt;
  logic [CW-1:0]   scan_cnt, scan_cnt_nxt;
  logic [PW-1:0]   base_x_nxt, base_y_nxt;
  logic            direction_nxt, step_pulse_nxt, shot_pulse_nxt;
  logic [3:0]      level_nxt;
  logic [IW-1:0]   shooter_id_nxt;
  logic            invaded_nxt, cleared_nxt;

  logic [COLS-1:0] col_any;
  logic [ROWS-1:0] row_any;
  logic [AW-1:0]   cmin, cmax, rmax, step_c, sum_x, sum_y;
  logic [IW-1:0]   idx_c;
  logic [CW-1:0]   cnt_c;
  logic            hit_c, right_hit_c, left_hit_c, edge_c, invade_c, clear_c;
  logic            act_c, move_tick_c, shot_tick_c, scan_en_c;

  // Occupied bounding box of the formation
  always_comb begin
    col_any = '0;
    row_any = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (alive[r*COLS + c]) begin
          col_any[c] = 1'b1;
          row_any[r] = 1'b1;
        end
    cmin = '0;
    cmax = '0;
    rmax = '0;
    for (int c = COLS - 1; c >= 0; c--) if (col_any[c]) cmin = AW'(c);
    for (int c = 0; c < COLS; c++) if (col_any[c]) cmax = AW'(c);
    for (int r = 0; r < ROWS; r++) if (row_any[r]) rmax = AW'(r);
  end

`ifdef FORMATION_ALIVE_SPEEDUP_EN
  logic [CW-1:0] pop_c;
  always_comb begin
    pop_c = '0;
    for (int i = 0; i < N; i++) pop_c = pop_c + CW'(alive[i]);
    step_c = AW'(1) + AW'(level) + ((pop_c <= CW'(N / 4)) ? AW'(1) : AW'(0));
  end
`else
  always_comb step_c = AW'(1) + AW'(level);
`endif

  // Edge, end-of-game and tick conditions
  always_comb begin
    right_hit_c = (AW'(base_x) + AW'(cmax * DIST_COL) + step_c) > AW'(X_MAX);
    left_hit_c  = (AW'(base_x) + AW'(cmin * DIST_COL)) < (AW'(X_MIN) + step_c);
    edge_c      = direction ? left_hit_c : right_hit_c;
    invade_c    = (AW'(base_y) + AW'(rmax * DIST_ROW)) >= AW'(Y_LIMIT);
    clear_c     = (alive == '0);
    act_c       = (state == S_MOVE) && run && !clear_c && !invade_c;
    move_tick_c = act_c && (step_cnt == SW'(STEP_DIV - 1));
    shot_tick_c = act_c && (shot_cnt == TW'(SHOT_DIV - 1));
    scan_en_c   = act_c && !(move_tick_c && edge_c);
  end

  always_ff @(posedge clk) begin
    if (reset || restart) state <= S_IDLE;
    else                  state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (run) state_nxt = S_MOVE;
      S_MOVE: begin
        if (clear_c || invade_c)       state_nxt = S_HALT;
        else if (!run)                 state_nxt = S_IDLE;
        else if (move_tick_c && edge_c) state_nxt = S_DESCEND;
      end
      S_DESCEND: state_nxt = invade_c ? S_HALT : S_MOVE;
      default:   state_nxt = S_HALT;
    endcase
  end

  // Next values of every registered output and of the dividers / scanner
  always_comb begin
    step_cnt_nxt   = step_cnt;
    shot_cnt_nxt   = shot_cnt;
    scanning_nxt   = 1'b0;
    scan_idx_nxt   = scan_idx;
    scan_cnt_nxt   = scan_cnt;
    base_x_nxt     = base_x;
    base_y_nxt     = base_y;
    direction_nxt  = direction;
    level_nxt      = level;
    step_pulse_nxt = 1'b0;
    shot_pulse_nxt = 1'b0;
    shooter_id_nxt = shooter_id;
    invaded_nxt    = invaded;
    cleared_nxt    = cleared;
    sum_x          = AW'(base_x) + step_c;
    sum_y          = AW'(base_y) + AW'(DELTA_Y);
    idx_c          = scanning ? scan_idx
                   : ((shooter_id == IW'(N - 1)) ? '0 : shooter_id + IW'(1));
    cnt_c          = scanning ? scan_cnt : '0;
    hit_c          = (alive & (N'(1) << idx_c)) != '0;

    if (act_c) begin
      step_cnt_nxt = (step_cnt == SW'(STEP_DIV - 1)) ? '0 : step_cnt + SW'(1);
      shot_cnt_nxt = (shot_cnt == TW'(SHOT_DIV - 1)) ? '0 : shot_cnt + TW'(1);
    end

    case (state)
      S_MOVE: begin
        if (clear_c)       cleared_nxt = 1'b1;
        else if (invade_c) invaded_nxt = 1'b1;
        else if (move_tick_c && !edge_c) begin
          step_pulse_nxt = 1'b1;
          if (direction) base_x_nxt = (AW'(base_x) < step_c) ? '0 : PW'(AW'(base_x) - step_c);
          else           base_x_nxt = (sum_x > PIX_MAX) ? '1 : PW'(sum_x);
        end
      end
      S_DESCEND: begin
        if (invade_c) invaded_nxt = 1'b1;
        else begin
          base_y_nxt     = (sum_y > PIX_MAX) ? '1 : PW'(sum_y);
          direction_nxt  = ~direction;
          level_nxt      = (level == 4'(MAX_LEVEL)) ? level : level + 4'd1;
          step_pulse_nxt = 1'b1;
        end
      end
      default: ;
    endcase

    // One candidate per cycle; stop on first live enemy or after a full lap
    if (scan_en_c && (scanning || shot_tick_c)) begin
      if (hit_c) begin
        shooter_id_nxt = idx_c;
        shot_pulse_nxt = 1'b1;
      end else if (cnt_c != CW'(N - 1)) begin
        scanning_nxt = 1'b1;
        scan_idx_nxt = (idx_c == IW'(N - 1)) ? '0 : idx_c + IW'(1);
        scan_cnt_nxt = cnt_c + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      step_cnt   <= '0;
      shot_cnt   <= '0;
      scanning   <= 1'b0;
      scan_idx   <= '0;
      scan_cnt   <= '0;
      base_x     <= PW'(X0);
      base_y     <= PW'(Y0);
      direction  <= 1'b0;
      level      <= '0;
      step_pulse <= 1'b0;
      shot_pulse <= 1'b0;
      shooter_id <= '0;
      invaded    <= 1'b0;
      cleared    <= 1'b0;
    end else begin
      step_cnt   <= step_cnt_nxt;
      shot_cnt   <= shot_cnt_nxt;
      scanning   <= scanning_nxt;
      scan_idx   <= scan_idx_nxt;
      scan_cnt   <= scan_cnt_nxt;
      base_x     <= base_x_nxt;
      base_y     <= base_y_nxt;
      direction  <= direction_nxt;
      level      <= level_nxt;
      step_pulse <= step_pulse_nxt;
      shot_pulse <= shot_pulse_nxt;
      shooter_id <= shooter_id_nxt;
      invaded    <= invaded_nxt;
      cleared    <= cleared_nxt;
    end
  end

endmodule

// File: tb/tb_formation_ctrl.sv
// Bench for formation_ctrl: directed scenarios plus random play against a cycle-level game model.
`timescale 1ns/1ps
module tb_formation_ctrl;
  localparam int ROWS = 5, COLS = 13, N = ROWS * COLS;
  localparam int STEP_DIV = 4, SHOT_DIV = 64;

  logic clk = 1'b0;
  logic reset, restart, run;
  logic [N-1:0] alive;
  logic [9:0] base_x, base_y;
  logic direction, step_pulse, shot_pulse, invaded, cleared;
  logic [3:0] level;
  logic [6:0] shooter_id;
  logic [35:0] dut_obs;

  int n_total = 0, n_pass = 0;

  formation_ctrl #(.STEP_DIV(STEP_DIV), .SHOT_DIV(SHOT_DIV)) dut (
    .clk(clk), .reset(reset), .restart(restart), .run(run), .alive(alive),
    .base_x(base_x), .base_y(base_y), .direction(direction), .level(level),
    .step_pulse(step_pulse), .shot_pulse(shot_pulse), .shooter_id(shooter_id),
    .invaded(invaded), .cleared(cleared));

  always #5 clk = ~clk;
  assign dut_obs = {base_x, base_y, direction, level, step_pulse, shot_pulse,
                    shooter_id, invaded, cleared};

  // Game model: position, phases of the two dividers and a lap-limited shooter search
  int m_bx, m_by, m_level, m_shooter, m_sph, m_tph, m_scan_pos, m_scan_left;
  bit m_dir, m_step_p, m_shot_p, m_inv, m_clr, m_on, m_drop, m_halt;

  function automatic int col_lo(input logic [N-1:0] a);
    for (int c = 0; c < COLS; c++) for (int r = 0; r < ROWS; r++) if (a[r*COLS + c]) return c;
    return 0;
  endfunction
  function automatic int col_hi(input logic [N-1:0] a);
    for (int c = COLS - 1; c >= 0; c--) for (int r = 0; r < ROWS; r++) if (a[r*COLS + c]) return c;
    return 0;
  endfunction
  function automatic int row_hi(input logic [N-1:0] a);
    for (int r = ROWS - 1; r >= 0; r--) for (int c = 0; c < COLS; c++) if (a[r*COLS + c]) return r;
    return 0;
  endfunction
  function automatic bit invading(input logic [N-1:0] a);
    return (m_by + row_hi(a) * 30) >= 440;
  endfunction
  function automatic int step_size(input logic [N-1:0] a);
    int s = 1 + m_level;
`ifdef FORMATION_ALIVE_SPEEDUP_EN
    if ($countones(a) <= N / 4) s = s + 1;
`endif
    return s;
  endfunction
  function automatic bit at_edge(input logic [N-1:0] a, input int stp);
    if (m_dir) return (m_bx + col_lo(a) * 30) < (120 + stp);
    return (m_bx + col_hi(a) * 30 + stp) > 760;
  endfunction
  function automatic logic [35:0] exp_obs();
    return {10'(m_bx), 10'(m_by), m_dir, 4'(m_level), m_step_p, m_shot_p,
            7'(m_shooter), m_inv, m_clr};
  endfunction

  always @(posedge clk) begin
    int stp;
    bit tick, stick;
    m_step_p = 1'b0;
    m_shot_p = 1'b0;
    if (reset || restart) begin
      m_bx = 150; m_by = 40; m_dir = 1'b0; m_level = 0; m_shooter = 0;
      m_inv = 1'b0; m_clr = 1'b0; m_on = 1'b0; m_drop = 1'b0; m_halt = 1'b0;
      m_sph = 0; m_tph = 0; m_scan_left = 0;
    end else if (m_halt) begin
    end else if (m_drop) begin
      m_drop = 1'b0;
      if (invading(alive)) begin m_inv = 1'b1; m_halt = 1'b1; end
      else begin
        m_by = m_by + 50; m_dir = !m_dir; m_step_p = 1'b1;
        if (m_level < 15) m_level = m_level + 1;
      end
    end else if (!m_on) m_on = run;
    else if (alive == '0) begin m_clr = 1'b1; m_halt = 1'b1; end
    else if (invading(alive)) begin m_inv = 1'b1; m_halt = 1'b1; end
    else if (!run) begin m_on = 1'b0; m_scan_left = 0; end
    else begin
      tick = (m_sph == STEP_DIV - 1); m_sph = (m_sph + 1) % STEP_DIV;
      stick = (m_tph == SHOT_DIV - 1); m_tph = (m_tph + 1) % SHOT_DIV;
      stp = step_size(alive);
      if (tick && at_edge(alive, stp)) begin m_drop = 1'b1; m_scan_left = 0; end
      else begin
        if (tick) begin
          if (m_dir) m_bx = (m_bx < stp) ? 0 : m_bx - stp;
          else m_bx = (m_bx + stp > 1023) ? 1023 : m_bx + stp;
          m_step_p = 1'b1;
        end
        if (stick && m_scan_left == 0) begin
          m_scan_pos = (m_shooter + 1) % N; m_scan_left = N;
        end
        if (m_scan_left > 0) begin
          if (alive[m_scan_pos]) begin
            m_shooter = m_scan_pos; m_shot_p = 1'b1; m_scan_left = 0;
          end else begin
            m_scan_left = m_scan_left - 1; m_scan_pos = (m_scan_pos + 1) % N;
          end
        end
      end
    end
  end

  task automatic do_restart();
    @(negedge clk); run = 1'b0; restart = 1'b1;
    @(negedge clk); restart = 1'b0;
  endtask

  task automatic test_reset();
    logic [35:0] rst_vec;
    rst_vec = {10'd150, 10'd40, 1'b0, 4'd0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0};
    repeat (2) @(negedge clk);
    n_total++;
    if (dut_obs !== rst_vec) $display("FAIL reset_values: got %h expected %h", dut_obs, rst_vec);
    else n_pass++;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); n_total++;
      if (dut_obs !== rst_vec) $display("FAIL idle_hold cyc %0d: got %h expected %h", i, dut_obs, rst_vec);
      else n_pass++;
    end
  endtask

  task automatic test_march();
    bit done = 1'b0;
    do_restart(); alive = '1; run = 1'b1;
    for (int i = 1; i <= 1200; i++) begin
      @(negedge clk); n_total++;
      if (dut_obs !== exp_obs()) $display("FAIL march cyc %0d: got %h expected %h", i, dut_obs, exp_obs());
      else n_pass++;
      if (i == 5 || i == 9) begin
        n_total++;
        if (step_pulse !== 1'b1 || base_x !== 10'(150 + (i - 1) / 4))
          $display("FAIL march_step cyc %0d: pulse %b x %0d", i, step_pulse, base_x);
        else n_pass++;
      end
      if (base_y !== 10'd40) begin
        n_total++;
        if (i != 1006 || base_x !== 10'd400 || base_y !== 10'd90 || direction !== 1'b1 || level !== 4'd1)
          $display("FAIL march_descent: cyc %0d x %0d y %0d dir %b lvl %0d expected 1006 400 90 1 1",
                   i, base_x, base_y, direction, level);
        else n_pass++;
        done = 1'b1;
        break;
      end
    end
    if (!done) begin n_total++; $display("FAIL march_timeout: no descent seen, expected one"); end
  endtask

  task automatic test_narrow();
    bit done = 1'b0;
    do_restart(); alive = '0; run = 1'b1;
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < 9; c++) alive[r*COLS + c] = 1'b1;
    for (int i = 1; i <= 2000; i++) begin
      @(negedge clk); n_total++;
      if (dut_obs !== exp_obs()) $display("FAIL narrow cyc %0d: got %h expected %h", i, dut_obs, exp_obs());
      else n_pass++;
      if (base_y !== 10'd40) begin
        n_total++;
        if (base_x !== 10'd520) $display("FAIL narrow_edge: x %0d expected 520", base_x);
        else n_pass++;
        done = 1'b1;
        break;
      end
    end
    if (!done) begin n_total++; $display("FAIL narrow_timeout: no descent seen, expected one"); end
  endtask

  task automatic test_shot();
    int at_q[$], id_q[$];
    int exp_at[3] = '{71, 161, 224};
    int exp_id[3] = '{7, 40, 7};
    do_restart(); alive = '0; alive[7] = 1'b1; alive[40] = 1'b1; run = 1'b1;
    for (int i = 1; i <= 240; i++) begin
      @(negedge clk); n_total++;
      if (dut_obs !== exp_obs()) $display("FAIL shot cyc %0d: got %h expected %h", i, dut_obs, exp_obs());
      else n_pass++;
      if (shot_pulse === 1'b1) begin at_q.push_back(i); id_q.push_back(int'(shooter_id)); end
    end
    n_total++;
    if (at_q.size() != 3) $display("FAIL shot_count: got %0d pulses expected 3", at_q.size());
    else n_pass++;
    for (int k = 0; k < 3 && k < at_q.size(); k++) begin
      n_total++;
      if (at_q[k] != exp_at[k] || id_q[k] != exp_id[k])
        $display("FAIL shot_%0d: cyc %0d id %0d expected cyc %0d id %0d", k, at_q[k], id_q[k], exp_at[k], exp_id[k]);
      else n_pass++;
    end
  endtask

  task automatic test_invade();
    bit done = 1'b0;
    logic [9:0] frozen_x;
    do_restart(); alive = '0; alive[COLS-1:0] = '1; run = 1'b1;
    for (int i = 1; i <= 8000; i++) begin
      @(negedge clk); n_total++;
      if (dut_obs !== exp_obs()) $display("FAIL invade cyc %0d: got %h expected %h", i, dut_obs, exp_obs());
      else n_pass++;
      if (invaded === 1'b1) begin done = 1'b1; break; end
    end
    n_total++;
    if (!done || base_y !== 10'd440 || cleared !== 1'b0)
      $display("FAIL invade_flag: inv %b y %0d clr %b expected 1 440 0", invaded, base_y, cleared);
    else n_pass++;
    frozen_x = base_x;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 20) alive = '0;
      n_total++;
      if (base_x !== frozen_x || step_pulse !== 1'b0 || shot_pulse !== 1'b0 || cleared !== 1'b0 || invaded !== 1'b1)
        $display("FAIL halt_freeze cyc %0d: x %0d sp %b sh %b clr %b inv %b expected x %0d 0 0 0 1",
                 i, base_x, step_pulse, shot_pulse, cleared, invaded, frozen_x);
      else n_pass++;
    end
  endtask

  task automatic test_clear();
    do_restart(); alive = N'({$urandom, $urandom, $urandom}) | N'(1); run = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk); n_total++;
      if (dut_obs !== exp_obs()) $display("FAIL clear_pre cyc %0d: got %h expected %h", i, dut_obs, exp_obs());
      else n_pass++;
    end
    alive = '0;
    @(negedge clk); n_total++;
    if (cleared !== 1'b1 || invaded !== 1'b0)
      $display("FAIL clear_flag: clr %b inv %b expected 1 0", cleared, invaded);
    else n_pass++;
  endtask

  task automatic test_restart_descend();
    bit done = 1'b0;
    do_restart(); alive = '1; run = 1'b1;
    for (int i = 1; i <= 1200; i++) begin
      @(negedge clk); n_total++;
      if (dut_obs !== exp_obs()) $display("FAIL rsd cyc %0d: got %h expected %h", i, dut_obs, exp_obs());
      else n_pass++;
      if (m_drop) begin done = 1'b1; break; end
    end
    if (!done) begin n_total++; $display("FAIL rsd_timeout: descent never reached, expected one"); end
    restart = 1'b1;
    @(negedge clk); restart = 1'b0; n_total++;
    if (base_x !== 10'd150 || base_y !== 10'd40 || level !== 4'd0 || step_pulse !== 1'b0 || direction !== 1'b0)
      $display("FAIL rsd_values: x %0d y %0d lvl %0d sp %b dir %b expected 150 40 0 0 0",
               base_x, base_y, level, step_pulse, direction);
    else n_pass++;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk); n_total++;
      if (dut_obs !== exp_obs()) $display("FAIL rsd_post cyc %0d: got %h expected %h", i, dut_obs, exp_obs());
      else n_pass++;
    end
  endtask

  task automatic test_speedup();
    int exp_step = 1;
    bit done = 1'b0;
`ifdef FORMATION_ALIVE_SPEEDUP_EN
    exp_step = 2;
`endif
    do_restart(); alive = '0; alive[15:0] = '1; run = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (step_pulse === 1'b1) begin done = 1'b1; break; end
    end
    n_total++;
    if (!done || base_x !== 10'(150 + exp_step))
      $display("FAIL speedup_step: seen %b x %0d expected x %0d", done, base_x, 150 + exp_step);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int round = 0; round < 4; round++) begin
      do_restart();
      if (round == 3) begin
        alive = '0;
        repeat (3) alive[$urandom_range(N - 1)] = 1'b1;
      end else alive = N'({$urandom, $urandom, $urandom});
      run = 1'b1;
      for (int i = 1; i <= 1500; i++) begin
        @(negedge clk); n_total++;
        if (dut_obs !== exp_obs())
          $display("FAIL random r%0d cyc %0d: got %h expected %h", round, i, dut_obs, exp_obs());
        else n_pass++;
        if ($urandom_range(99) < 3) alive[$urandom_range(N - 1)] = 1'b0;
        if ($urandom_range(199) == 0) run = !run;
        restart = ($urandom_range(999) == 0);
      end
      restart = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; restart = 1'b0; run = 1'b0; alive = '1;
    test_reset();
    test_march();
    test_narrow();
    test_shot();
    test_invade();
    test_clear();
    test_restart_descend();
    test_speedup();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
